// File: rtl/calc_pkg.sv
// calc_pkg: shared types and default timing constants for the calculator
// control block (display-mode encoding, FSM states, debounce/linger defaults).
package calc_pkg;

  // Select code driven to the downstream value mux.
  typedef enum logic [1:0] {
    DISP_SW     = 2'd0,
    DISP_STORED = 2'd1,
    DISP_SUM    = 2'd2,
    DISP_DIFF   = 2'd3
  } disp_mode_e;

  // Display-mode state machine states.
  typedef enum logic [2:0] {
    SHOW_SW     = 3'd0,
    SHOW_STORED = 3'd1,
    SHOW_SUM    = 3'd2,
    SHOW_DIFF   = 3'd3,
    LINGER      = 3'd4
  } calc_state_e;

  // 4 ms of stable input at 12 MHz.
  localparam logic [15:0] DB_CYCLES_DEF     = 16'd48000;
  // 0.5 s of linger at 12 MHz.
  localparam logic [23:0] LINGER_CYCLES_DEF = 24'd6000000;

  // Display code for a state; LINGER keeps showing whatever was last shown.
  function automatic disp_mode_e state_mode(input calc_state_e st, input disp_mode_e last);
    disp_mode_e m;
    case (st)
      SHOW_SW:     m = DISP_SW;
      SHOW_STORED: m = DISP_STORED;
      SHOW_SUM:    m = DISP_SUM;
      SHOW_DIFF:   m = DISP_DIFF;
      LINGER:      m = last;
      default:     m = DISP_SW;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/calc_ctrl_btn_debounce.sv
// btn_debounce: 2-flop synchroniser followed by a consecutive-cycle debouncer.
// The debounced level flips once the synchronised input has disagreed with it
// for DB_CYCLES cycles in a row; any agreeing cycle restarts the count.
// 'fall' is high in the cycle whose closing edge drops the debounced level.
module btn_debounce
  import calc_pkg::*;
#(
  parameter logic [15:0] DB_CYCLES = DB_CYCLES_DEF,
  parameter logic        RST_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic fall,
  output logic sync_level
);

  logic        sync1_q;
  logic        sync2_q;
  logic        level_q;
  logic        level_d;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic [15:0] cnt_inc_s;
  logic        flip_s;

  assign cnt_inc_s = cnt_q + 16'd1;

  // Count disagreeing cycles and flip the level when the run is long enough.
  always_comb begin
    level_d = level_q;
    cnt_d   = 16'd0;
    flip_s  = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_inc_s >= DB_CYCLES) begin
        flip_s  = 1'b1;
        level_d = sync2_q;
        cnt_d   = 16'd0;
      end else begin
        cnt_d = cnt_inc_s;
      end
    end else begin
      cnt_d = 16'd0;
    end
  end

  // Synchroniser, debounced level and run counter; reset to the released level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= RST_VAL;
      sync2_q <= RST_VAL;
      level_q <= RST_VAL;
      cnt_q   <= 16'd0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level      = level_q;
  assign fall       = flip_s & level_q;
  assign sync_level = sync2_q;

endmodule

// File: rtl/calc_ctrl.sv
// calc_ctrl: button conditioning, stored-operand register and display-mode
// FSM for the switch/stored-value calculator.
// Build option: define CALC_ACCUM_EN to make a store taken while SUM is shown
// accumulate (stored_value <= sw + stored_value, mod 256) instead of loading sw.
module calc_ctrl
  import calc_pkg::*;
#(
  parameter logic [15:0] DB_CYCLES     = DB_CYCLES_DEF,
  parameter logic [23:0] LINGER_CYCLES = LINGER_CYCLES_DEF
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       btn_sum,
  input  logic       btn_stored,
  input  logic       btn_diff,
  input  logic       btn_store_n,
  input  logic [7:0] sw,
  output logic [7:0] stored_value,
  output logic [1:0] disp_sel,
  output logic       store_pulse
);

  logic        db_sum_s;
  logic        db_stored_s;
  logic        db_diff_s;
  logic        db_store_n_s;
  logic        store_fall_s;
  logic        store_sync_s;
  logic [5:0]  mode_unused_s;

  logic        req_any_s;
  calc_state_e req_state_s;
  logic        store_ev_s;

  calc_state_e state_q, state_d;
  logic [23:0] linger_q, linger_d;
  disp_mode_e  disp_q, disp_d;
  logic [7:0]  stored_q, stored_d;
  logic        pulse_q, pulse_d;
  logic [1:0]  warm_q, warm_d;
  logic        armed_q, armed_d;

  btn_debounce #(.DB_CYCLES(DB_CYCLES), .RST_VAL(1'b0)) u_db_sum (
    .clk(CLK), .rst_n(RST_N), .btn_raw(btn_sum),
    .level(db_sum_s), .fall(mode_unused_s[0]), .sync_level(mode_unused_s[1])
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES), .RST_VAL(1'b0)) u_db_stored (
    .clk(CLK), .rst_n(RST_N), .btn_raw(btn_stored),
    .level(db_stored_s), .fall(mode_unused_s[2]), .sync_level(mode_unused_s[3])
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES), .RST_VAL(1'b0)) u_db_diff (
    .clk(CLK), .rst_n(RST_N), .btn_raw(btn_diff),
    .level(db_diff_s), .fall(mode_unused_s[4]), .sync_level(mode_unused_s[5])
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES), .RST_VAL(1'b1)) u_db_store (
    .clk(CLK), .rst_n(RST_N), .btn_raw(btn_store_n),
    .level(db_store_n_s), .fall(store_fall_s), .sync_level(store_sync_s)
  );

  // Highest-priority debounced mode request: diff > sum > stored.
  always_comb begin
    req_any_s = db_diff_s | db_sum_s | db_stored_s;
    if (db_diff_s) begin
      req_state_s = SHOW_DIFF;
    end else if (db_sum_s) begin
      req_state_s = SHOW_SUM;
    end else if (db_stored_s) begin
      req_state_s = SHOW_STORED;
    end else begin
      req_state_s = SHOW_SW;
    end
  end

  // Store arming: a store button held through reset must be seen released
  // (after the synchroniser has refilled) before its falling edge counts.
  always_comb begin
    if (warm_q != 2'd2) begin
      warm_d = warm_q + 2'd1;
    end else begin
      warm_d = warm_q;
    end
    armed_d    = armed_q | ((warm_q == 2'd2) & store_sync_s);
    store_ev_s = store_fall_s & armed_q;
  end

  // Stored-operand update and one-cycle strobe on an armed debounced press.
  always_comb begin
    stored_d = stored_q;
    pulse_d  = 1'b0;
    if (store_ev_s) begin
      pulse_d = 1'b1;
`ifdef CALC_ACCUM_EN
      if (disp_q == DISP_SUM) begin
        stored_d = sw + stored_q;
      end else begin
        stored_d = sw;
      end
`else
      stored_d = sw;
`endif
    end else begin
      stored_d = stored_q;
    end
  end

  // Display-mode next state, linger countdown and registered select code.
  always_comb begin
    state_d  = state_q;
    linger_d = linger_q;
    case (state_q)
      SHOW_SW: begin
        if (req_any_s) begin
          state_d = req_state_s;
        end else begin
          state_d = SHOW_SW;
        end
      end
      SHOW_STORED, SHOW_SUM, SHOW_DIFF: begin
        if (req_any_s) begin
          state_d = req_state_s;
        end else if (LINGER_CYCLES == 24'd0) begin
          state_d = SHOW_SW;
        end else begin
          state_d  = LINGER;
          linger_d = LINGER_CYCLES - 24'd1;
        end
      end
      LINGER: begin
        if (req_any_s) begin
          state_d  = req_state_s;
          linger_d = 24'd0;
        end else if (linger_q == 24'd0) begin
          state_d = SHOW_SW;
        end else begin
          linger_d = linger_q - 24'd1;
        end
      end
      default: begin
        state_d  = SHOW_SW;
        linger_d = 24'd0;
      end
    endcase
    disp_d = state_mode(state_d, disp_q);
  end

  // All control-block state; asynchronous return to the idle/released values.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= SHOW_SW;
      linger_q <= 24'd0;
      disp_q   <= DISP_SW;
      stored_q <= 8'h00;
      pulse_q  <= 1'b0;
      warm_q   <= 2'd0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      linger_q <= linger_d;
      disp_q   <= disp_d;
      stored_q <= stored_d;
      pulse_q  <= pulse_d;
      warm_q   <= warm_d;
      armed_q  <= armed_d;
    end
  end

  assign stored_value = stored_q;
  assign disp_sel     = disp_q;
  assign store_pulse  = pulse_q;

endmodule

// File: tb/tb_calc_ctrl.sv
// tb_calc_ctrl: self-checking bench for calc_ctrl with DB_CYCLES=4 and
// LINGER_CYCLES=8. Mode selection is table driven; stores are checked through
// a scoreboard queue filled when a store press is driven.
module tb_calc_ctrl;

  logic       CLK;
  logic       RST_N;
  logic       btn_sum;
  logic       btn_stored;
  logic       btn_diff;
  logic       btn_store_n;
  logic [7:0] sw;
  logic [7:0] stored_value;
  logic [1:0] disp_sel;
  logic       store_pulse;

  int n_vec = 0;
  int n_bad = 0;
  int pulse_cnt = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic       sum;
    logic       stored;
    logic       diff;
    logic [1:0] exp_sel;
  } mode_vec_t;

  mode_vec_t vecs[6];

  calc_ctrl #(.DB_CYCLES(16'd4), .LINGER_CYCLES(24'd8)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .btn_sum(btn_sum), .btn_stored(btn_stored), .btn_diff(btn_diff),
    .btn_store_n(btn_store_n), .sw(sw),
    .stored_value(stored_value), .disp_sel(disp_sel), .store_pulse(store_pulse)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every store strobe must match the oldest expected value.
  always @(negedge CLK) begin
    if (RST_N && store_pulse) begin
      pulse_cnt++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_store: got stored_value %0h with no store expected", stored_value);
      end else begin
        check("sb_store", {24'd0, stored_value}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    logic [1:0] prev_sel;
    logic [7:0] acc_exp;

    vecs[0] = '{sum: 1'b0, stored: 1'b1, diff: 1'b0, exp_sel: 2'd1};
    vecs[1] = '{sum: 1'b1, stored: 1'b1, diff: 1'b0, exp_sel: 2'd2};
    vecs[2] = '{sum: 1'b1, stored: 1'b1, diff: 1'b1, exp_sel: 2'd3};
    vecs[3] = '{sum: 1'b0, stored: 1'b1, diff: 1'b1, exp_sel: 2'd3};
    vecs[4] = '{sum: 1'b0, stored: 1'b1, diff: 1'b0, exp_sel: 2'd1};
    vecs[5] = '{sum: 1'b1, stored: 1'b0, diff: 1'b0, exp_sel: 2'd2};

    // Reset with the store button held low.
    RST_N = 1'b0; btn_sum = 1'b0; btn_stored = 1'b0; btn_diff = 1'b0;
    btn_store_n = 1'b0; sw = 8'hA5;
    cyc(3);
    check("rst_disp", {30'd0, disp_sel}, 32'd0);
    check("rst_stored", {24'd0, stored_value}, 32'd0);
    check("rst_pulse", {31'd0, store_pulse}, 32'd0);
    RST_N = 1'b1;
    cyc(20);
    check("held_no_store", {24'd0, stored_value}, 32'd0);
    check("held_no_pulse", pulse_cnt, 32'd0);
    btn_store_n = 1'b1;
    cyc(12);

    // Bouncy press, then hold: one store exactly 6 cycles after stable low.
    sw = 8'h3C;
    btn_store_n = 1'b0; cyc(3);
    btn_store_n = 1'b1; cyc(1);
    btn_store_n = 1'b0; cyc(2);
    btn_store_n = 1'b1; cyc(3);
    exp_q.push_back(8'h3C);
    btn_store_n = 1'b0;
    cyc(5);
    check("store_early_pulse", {31'd0, store_pulse}, 32'd0);
    check("store_early_val", {24'd0, stored_value}, 32'd0);
    cyc(1);
    check("store_pulse", {31'd0, store_pulse}, 32'd1);
    check("store_val", {24'd0, stored_value}, 32'h3C);
    cyc(20);
    check("store_once", pulse_cnt, 32'd1);
    btn_store_n = 1'b1;
    cyc(10);

    // Mode table: old select still shown at 6 cycles, new one at 7.
    prev_sel = 2'd0;
    for (int i = 0; i < 6; i++) begin
      btn_sum = vecs[i].sum; btn_stored = vecs[i].stored; btn_diff = vecs[i].diff;
      cyc(6);
      check($sformatf("mode_hold_%0d", i), {30'd0, disp_sel}, {30'd0, prev_sel});
      cyc(1);
      check($sformatf("mode_sel_%0d", i), {30'd0, disp_sel}, {30'd0, vecs[i].exp_sel});
      prev_sel = vecs[i].exp_sel;
    end

    // SUM held, add DIFF, release both: DIFF lingers 8 cycles then SW.
    btn_diff = 1'b1;
    cyc(7);
    check("sum_diff_sel", {30'd0, disp_sel}, 32'd3);
    btn_sum = 1'b0; btn_diff = 1'b0;
    cyc(7);
    check("linger_enter", {30'd0, disp_sel}, 32'd3);
    cyc(7);
    check("linger_last", {30'd0, disp_sel}, 32'd3);
    cyc(1);
    check("linger_done", {30'd0, disp_sel}, 32'd0);

    // STORED linger interrupted by a SUM press debounced at linger cycle 4.
    btn_stored = 1'b1;
    cyc(7);
    check("stored_sel", {30'd0, disp_sel}, 32'd1);
    btn_stored = 1'b0;
    cyc(4);
    btn_sum = 1'b1;
    cyc(6);
    check("linger_hold", {30'd0, disp_sel}, 32'd1);
    cyc(1);
    check("linger_exit_sum", {30'd0, disp_sel}, 32'd2);
    cyc(10);
    check("sum_no_return", {30'd0, disp_sel}, 32'd2);
    btn_sum = 1'b0;
    cyc(20);
    check("sum_released", {30'd0, disp_sel}, 32'd0);

    // Store F0 in SW mode, then store 20 while SUM is shown.
    sw = 8'hF0;
    exp_q.push_back(8'hF0);
    btn_store_n = 1'b0; cyc(8);
    btn_store_n = 1'b1; cyc(8);
    btn_sum = 1'b1;
    cyc(7);
    check("sum_for_store", {30'd0, disp_sel}, 32'd2);
`ifdef CALC_ACCUM_EN
    acc_exp = 8'h10;
`else
    acc_exp = 8'h20;
`endif
    sw = 8'h20;
    exp_q.push_back(acc_exp);
    btn_store_n = 1'b0; cyc(8);
    check("sum_store_val", {24'd0, stored_value}, {24'd0, acc_exp});
    check("store_keeps_mode", {30'd0, disp_sel}, 32'd2);
    btn_store_n = 1'b1; cyc(8);
    btn_sum = 1'b0;
    cyc(20);
    check("sum2_released", {30'd0, disp_sel}, 32'd0);

    // Reset asserted mid-LINGER takes effect before the next clock edge.
    btn_diff = 1'b1;
    cyc(7);
    check("diff_sel", {30'd0, disp_sel}, 32'd3);
    btn_diff = 1'b0;
    cyc(9);
    check("mid_linger", {30'd0, disp_sel}, 32'd3);
    RST_N = 1'b0;
    #1;
    check("async_rst_disp", {30'd0, disp_sel}, 32'd0);
    check("async_rst_stored", {24'd0, stored_value}, 32'd0);
    check("async_rst_pulse", {31'd0, store_pulse}, 32'd0);
    cyc(2);
    RST_N = 1'b1;
    cyc(10);
    check("post_rst_disp", {30'd0, disp_sel}, 32'd0);
    check("post_rst_stored", {24'd0, stored_value}, 32'd0);
    check("sb_empty", exp_q.size(), 32'd0);
    check("pulse_total", pulse_cnt, 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
